// File: rtl/jogo_sequencia_controle.sv
// Moore control FSM for the sequence-memory game.
// Define JOGO_TIMEOUT_EN to enable the move timeout path (fim_T).
module jogo_sequencia_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL    = 4'h0;
  localparam logic [3:0] PREPARACAO = 4'h1;
  localparam logic [3:0] INICIA_ROD = 4'h2;
  localparam logic [3:0] ESPERA     = 4'h3;
  localparam logic [3:0] REGISTRA   = 4'h4;
  localparam logic [3:0] COMPARACAO = 4'h5;
  localparam logic [3:0] PROX_JOG   = 4'h6;
  localparam logic [3:0] PROX_ROD   = 4'h7;
  localparam logic [3:0] FIM_A      = 4'hA;
  localparam logic [3:0] FIM_T      = 4'hB;
  localparam logic [3:0] FIM_E      = 4'hE;

`ifdef JOGO_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic [3:0] state;
  logic [3:0] next;
  logic       to_hit;

  assign to_hit = timeout & TO_EN;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= next;
  end

  always_comb begin
    next = INICIAL;
    case (state)
      INICIAL:    next = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: next = INICIA_ROD;
      INICIA_ROD: next = ESPERA;
      ESPERA: begin
        if (to_hit)      next = FIM_T;
        else if (jogada) next = REGISTRA;
        else             next = ESPERA;
      end
      REGISTRA:   next = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     next = FIM_E;
        else if (!fimE) next = PROX_JOG;
        else if (!fimL) next = PROX_ROD;
        else            next = FIM_A;
      end
      PROX_JOG:   next = ESPERA;
      PROX_ROD:   next = INICIA_ROD;
      FIM_A:      next = iniciar ? PREPARACAO : FIM_A;
      FIM_E:      next = iniciar ? PREPARACAO : FIM_E;
      // Without the timeout feature fim_T is treated as an illegal code
      FIM_T: begin
        if (!TO_EN)       next = INICIAL;
        else if (iniciar) next = PREPARACAO;
        else              next = FIM_T;
      end
      default:    next = INICIAL;
    endcase
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraL      = 1'b0;
    contaL     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    zeraT      = 1'b0;
    contaT     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    db_estado  = 4'hF;
    case (state)
      INICIAL, PREPARACAO: begin
        zeraE     = 1'b1;
        zeraL     = 1'b1;
        zeraR     = 1'b1;
        zeraT     = 1'b1;
        db_estado = state;
      end
      INICIA_ROD: begin
        zeraE     = 1'b1;
        zeraT     = 1'b1;
        db_estado = state;
      end
      ESPERA: begin
        contaT    = TO_EN;
        db_estado = state;
      end
      REGISTRA: begin
        registraR = 1'b1;
        db_estado = state;
      end
      COMPARACAO: db_estado = state;
      PROX_JOG: begin
        contaE    = 1'b1;
        zeraT     = 1'b1;
        db_estado = state;
      end
      PROX_ROD: begin
        contaL    = 1'b1;
        db_estado = state;
      end
      FIM_A: begin
        ganhou    = 1'b1;
        pronto    = 1'b1;
        db_estado = state;
      end
      FIM_E: begin
        perdeu    = 1'b1;
        pronto    = 1'b1;
        db_estado = state;
      end
      FIM_T: begin
        if (TO_EN) begin
          perdeu     = 1'b1;
          pronto     = 1'b1;
          db_timeout = 1'b1;
          db_estado  = state;
        end
      end
      default: db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_jogo_sequencia_controle.sv
// Directed bench for jogo_sequencia_controle.
// Outputs are sampled 1 time unit after each rising edge.
module tb_jogo_sequencia_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b0;
  logic       fimE = 1'b0;
  logic       fimL = 1'b0;
  logic       timeout = 1'b0;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       zeraT, contaT, ganhou, perdeu, pronto, db_timeout;
  logic [3:0] db_estado;

  int total = 0;
  int bad = 0;

  jogo_sequencia_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL), .timeout(timeout),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] outs();
    return {zeraE, contaE, zeraL, contaL, zeraR, registraR,
            zeraT, contaT, ganhou, perdeu, pronto, db_timeout};
  endfunction

  // Expected Moore output table, same bit order as outs()
  function automatic logic [11:0] spec_outs(logic [3:0] s);
    logic ze, ce, zl, cl, zr, rr, zt, ct, g, p, pr, dt;
    ze = (s == 4'h0) || (s == 4'h1) || (s == 4'h2);
    ce = (s == 4'h6);
    zl = (s == 4'h0) || (s == 4'h1);
    cl = (s == 4'h7);
    zr = zl;
    rr = (s == 4'h4);
    zt = ze || (s == 4'h6);
`ifdef JOGO_TIMEOUT_EN
    ct = (s == 4'h3);
`else
    ct = 1'b0;
`endif
    g  = (s == 4'hA);
    p  = (s == 4'hE) || (s == 4'hB);
    pr = g || p;
    dt = (s == 4'hB);
    return {ze, ce, zl, cl, zr, rr, zt, ct, g, p, pr, dt};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(logic [4:0] v);
    {iniciar, jogada, igual, fimE, fimL} = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(5'b0);
    timeout = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if (db_estado !== 4'h0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", db_estado);
    end
    total++;
    if (outs() !== spec_outs(4'h0)) begin
      bad++;
      $display("FAIL reset_outs got=%b want=%b", outs(), spec_outs(4'h0));
    end
    step();
    reset = 1'b0;
    step();
    total++;
    if (db_estado !== 4'h0) begin
      bad++;
      $display("FAIL reset_idle got=%h want=0", db_estado);
    end
  endtask

  task automatic test_win();
    logic [8:0] v[$];
    int npulse = 0;
    v = '{{5'b10000, 4'h1}, {5'b00000, 4'h2}, {5'b00000, 4'h3},
          {5'b01110, 4'h4}, {5'b00110, 4'h5}, {5'b00110, 4'h7},
          {5'b00110, 4'h2}, {5'b00110, 4'h3}, {5'b01101, 4'h4},
          {5'b00101, 4'h5}, {5'b00101, 4'h6}, {5'b00101, 4'h3},
          {5'b01111, 4'h4}, {5'b00111, 4'h5}, {5'b00111, 4'hA},
          {5'b00000, 4'hA}, {5'b00000, 4'hA}};
    do_reset();
    foreach (v[i]) begin
      apply(v[i][8:4]);
      step();
      if (contaL === 1'b1) npulse++;
      total++;
      if (db_estado !== v[i][3:0]) begin
        bad++;
        $display("FAIL win_state step=%0d got=%h want=%h",
                 i, db_estado, v[i][3:0]);
      end
      total++;
      if (outs() !== spec_outs(v[i][3:0])) begin
        bad++;
        $display("FAIL win_outs step=%0d got=%b want=%b",
                 i, outs(), spec_outs(v[i][3:0]));
      end
    end
    total++;
    if (npulse != 1) begin
      bad++;
      $display("FAIL win_contaL_pulses got=%0d want=1", npulse);
    end
  endtask

  task automatic test_error();
    logic [8:0] v[$];
    v = '{{5'b10000, 4'h1}, {5'b00000, 4'h2}, {5'b00000, 4'h3},
          {5'b01000, 4'h4}, {5'b00000, 4'h5}, {5'b00000, 4'hE},
          {5'b00000, 4'hE}, {5'b01110, 4'hE}, {5'b00000, 4'hE}};
    do_reset();
    foreach (v[i]) begin
      apply(v[i][8:4]);
      step();
      total++;
      if (db_estado !== v[i][3:0]) begin
        bad++;
        $display("FAIL err_state step=%0d got=%h want=%h",
                 i, db_estado, v[i][3:0]);
      end
      total++;
      if (outs() !== spec_outs(v[i][3:0])) begin
        bad++;
        $display("FAIL err_outs step=%0d got=%b want=%b",
                 i, outs(), spec_outs(v[i][3:0]));
      end
    end
  endtask

  task automatic test_restart();
    apply(5'b10000);
    step();
    total++;
    if (db_estado !== 4'h1) begin
      bad++;
      $display("FAIL restart_state got=%h want=1", db_estado);
    end
    total++;
    if ({zeraL, zeraE, zeraR, zeraT, perdeu} !== 5'b11110) begin
      bad++;
      $display("FAIL restart_zera got=%b want=11110",
               {zeraL, zeraE, zeraR, zeraT, perdeu});
    end
    apply(5'b00000);
    step();
    total++;
    if (db_estado !== 4'h2 || zeraL !== 1'b0) begin
      bad++;
      $display("FAIL restart_next got=%h/%b want=2/0", db_estado, zeraL);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(5'b10000);
    step();
    apply(5'b00000);
    step();
    step();
    total++;
    if (db_estado !== 4'h3) begin
      bad++;
      $display("FAIL mid_pre got=%h want=3", db_estado);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (db_estado !== 4'h0 || contaT !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got=%h/%b want=0/0", db_estado, contaT);
    end
    #2;
    reset = 1'b0;
    step();
    total++;
    if (db_estado !== 4'h0 || outs() !== spec_outs(4'h0)) begin
      bad++;
      $display("FAIL mid_after got=%h/%b want=0/%b",
               db_estado, outs(), spec_outs(4'h0));
    end
  endtask

`ifdef JOGO_TIMEOUT_EN
  task automatic test_timeout();
    int nreg = 0;
    do_reset();
    apply(5'b10000);
    step();
    apply(5'b00000);
    step();
    step();
    total++;
    if (contaT !== 1'b1) begin
      bad++;
      $display("FAIL to_contaT got=%b want=1", contaT);
    end
    apply(5'b01000);
    timeout = 1'b1;
    step();
    if (registraR === 1'b1) nreg++;
    apply(5'b00000);
    timeout = 1'b0;
    total++;
    if (db_estado !== 4'hB) begin
      bad++;
      $display("FAIL to_state got=%h want=B", db_estado);
    end
    total++;
    if (outs() !== spec_outs(4'hB)) begin
      bad++;
      $display("FAIL to_outs got=%b want=%b", outs(), spec_outs(4'hB));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (registraR === 1'b1) nreg++;
    end
    total++;
    if (db_estado !== 4'hB || nreg != 0) begin
      bad++;
      $display("FAIL to_hold got=%h/%0d want=B/0", db_estado, nreg);
    end
  endtask
`else
  task automatic test_macro_off();
    int nbad = 0;
    do_reset();
    apply(5'b10000);
    step();
    apply(5'b00000);
    step();
    step();
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (db_estado !== 4'h3 || contaT !== 1'b0 ||
          db_timeout !== 1'b0) nbad++;
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL off_hold got=%0d bad_cycles want=0", nbad);
    end
    apply(5'b01000);
    step();
    timeout = 1'b0;
    apply(5'b00000);
    total++;
    if (db_estado !== 4'h4) begin
      bad++;
      $display("FAIL off_jogada got=%h want=4", db_estado);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_win();
    test_error();
    test_restart();
    test_reset_mid();
`ifdef JOGO_TIMEOUT_EN
    test_timeout();
`else
    test_macro_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jogo_sequencia_controle.md
JOGO_SEQUENCIA_CONTROLE -- requirements
Module: jogo_sequencia_controle

Interface
REQ-001 SHALL have no parameters; state encodings are fixed by REQ-014.
REQ-002 SHALL have port clock  input  1  single system clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have inputs iniciar, jogada, igual, fimE, fimL, timeout, each 1 bit:
- iniciar: start request.
- jogada: player move strobe.
- igual: comparator match.
- fimE: address counter at current-round limit.
- fimL: round counter at last round.
- timeout: move-timer expired.
REQ-005 SHALL have outputs zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT, each 1 bit: clear/enable for the address counter, round counter, move register and timeout timer.
REQ-006 SHALL have outputs ganhou, perdeu, pronto, db_timeout (1 bit each) and db_estado (4 bits, current state code).

Function
REQ-007 SHALL be a Moore FSM; every output SHALL be decoded from the current state only.
REQ-008 SHALL update state on the rising clock edge only.
REQ-009 SHALL take these transitions:
- inicial -> preparacao if iniciar, else stay.
- preparacao -> inicia_rodada.
- inicia_rodada -> espera.
- proxima_jogada -> espera.
- registra -> comparacao.
- proxima_rodada -> inicia_rodada.
REQ-010 SHALL leave espera as follows: timeout -> fim_T; else jogada -> registra; else stay. timeout has priority over a simultaneous jogada.
REQ-011 SHALL leave comparacao with this priority: !igual -> fim_E; igual&!fimE -> proxima_jogada; igual&fimE&!fimL -> proxima_rodada; igual&fimE&fimL -> fim_A.
REQ-012 SHALL hold fim_A, fim_E and fim_T until iniciar, then go to preparacao (restart without reset).
REQ-013 SHALL send any unlisted state code to inicial on the next edge.
REQ-014 SHALL drive db_estado with these codes:
- inicial 0, preparacao 1, inicia_rodada 2, espera 3, registra 4.
- comparacao 5, proxima_jogada 6, proxima_rodada 7.
- fim_A A, fim_T B, fim_E E.
- illegal state F.
REQ-015 SHALL decode outputs as:
- zeraL and zeraR: in inicial and preparacao.
- zeraE: in inicial, preparacao and inicia_rodada.
- zeraT: in inicial, preparacao, inicia_rodada and proxima_jogada.
- contaT: in espera only.
- registraR: in registra only.
- contaE: in proxima_jogada only.
- contaL: in proxima_rodada only.
- pronto: in fim_A, fim_E and fim_T.
- ganhou: in fim_A only.
- perdeu: in fim_E and fim_T.
- db_timeout: in fim_T only.
REQ-016 SHALL take exactly 3 cycles from the jogada-sampling edge (in espera) back to espera on a matched non-final move (registra, comparacao, proxima_jogada).
REQ-017 SHALL hold each count/clear pulse for exactly one cycle per state visit, so the datapath counters advance by exactly 1.

Reset
REQ-018 SHALL force state inicial immediately on reset=1, independent of clock.
REQ-019 SHALL present these outputs during and after reset: zeraE=zeraL=zeraR=zeraT=1, all other 1-bit outputs 0, db_estado=0.
REQ-020 SHALL abandon any state on reset asserted mid-game, with no residual pulses on the next cycle.

Configuration
REQ-021 SHALL, when macro JOGO_TIMEOUT_EN is defined, implement timeout per REQ-010 and REQ-015.
REQ-022 SHALL, when JOGO_TIMEOUT_EN is undefined:
- ignore the timeout input.
- wait in espera indefinitely.
- tie contaT and db_timeout to 0.
- make fim_T unreachable (illegal-state handling per REQ-013 still applies).

Verification
REQ-023 SHALL cover win: reset, iniciar=1 for 1 cycle, 2 rounds (fimL=1 on round 2), all igual=1 -> db_estado 0,1,2,3,4,5,7,2,...; ends in A with ganhou=1, pronto=1; contaL pulsed once.
REQ-024 SHALL cover error: in round 1, jogada with igual=0 -> db_estado 4 then 5 then E; perdeu=1, pronto=1, ganhou=0; holds until iniciar.
REQ-025 SHALL cover timeout (JOGO_TIMEOUT_EN defined): in espera, assert timeout and jogada in the same cycle -> next state B, db_timeout=1, perdeu=1, registraR never pulses.
REQ-026 SHALL cover restart: from E, pulse iniciar -> state 1 with zeraL=zeraE=zeraR=zeraT=1 for one cycle, then 2.
REQ-027 SHALL cover reset mid-game: reset pulse between clock edges while in espera (3) -> db_estado=0 at once; contaT=0 before the next edge.
REQ-028 SHALL cover macro off: build without JOGO_TIMEOUT_EN, hold timeout=1 in espera for 20 cycles -> stays 3, contaT=0; jogada then moves to 4.
